// File: rtl/win_pkg.sv
// Shared types and board-geometry helpers for the sequential win detector.
// Cell (r,c) with r=0 the top row maps to bit N*N-1-(r*N+c).
package win_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Line groups; line_base() turns a group into its first line index.
   localparam int ROW0    = 0;
   localparam int COL0    = 1;
   localparam int DIAG_DN = 2;
   localparam int DIAG_UP = 3;

   function automatic int nlines(input int n);
      return 2 * n + 2;
   endfunction

   function automatic int cell_bit(input int n, input int r, input int c);
      return n * n - 1 - (r * n + c);
   endfunction

   function automatic int line_base(input int n, input int grp);
      case (grp)
         ROW0:    return 0;
         COL0:    return n;
         DIAG_DN: return 2 * n;
         default: return 2 * n + 1;
      endcase
   endfunction

endpackage

// File: rtl/line_mask_gen.sv
// Combinational decoder: line index -> N*N-bit mask of the cells on that line.
// Rows first, then columns, then the down and up diagonals.
module line_mask_gen
   import win_pkg::*;
#(
   parameter  int N    = 3,
   localparam int NL   = nlines(N),
   localparam int IDXW = $clog2(NL)
) (
   input  logic [IDXW-1:0] idx,
   output logic [N*N-1:0]  mask
);

   function automatic logic on_line(input int sel, input int r, input int c);
      return (sel == line_base(N, ROW0) + r) ||
             (sel == line_base(N, COL0) + c) ||
             ((sel == line_base(N, DIAG_DN)) && (r == c)) ||
             ((sel == line_base(N, DIAG_UP)) && (r + c == N - 1));
   endfunction

   always_comb begin
      mask = '0;
      for (int b = 0; b < N * N; b++) begin
         mask[b] = on_line(int'(idx), (N * N - 1 - b) / N, (N * N - 1 - b) % N);
      end
   end

endmodule

// File: rtl/seq_win_detector.sv
// Sequential N-in-a-row win detector: latches both boards on start, then
// tests one candidate line per clock; first hit in index order wins.
module seq_win_detector
   import win_pkg::*;
#(
   parameter  int N  = 3,
   localparam int NL = nlines(N),
   localparam int NC = N * N
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NC-1:0] ain,
   input  logic [NC-1:0] bin,
   output logic          busy,
   output logic          done,
   output logic [NL-1:0] win_line,
   output logic          winner_a,
   output logic          winner_b,
   output logic          draw,
   output logic          invalid
);

   localparam int              IDXW = $clog2(NL);
   localparam logic [IDXW-1:0] LAST = IDXW'(NL - 1);
   localparam logic [NL-1:0]   ONE  = NL'(1);

   state_t          state;
   logic [NC-1:0]   a_q, b_q;
   logic [IDXW-1:0] idx;
   logic [NC-1:0]   mask;
   logic            hit_a, hit_b, clash;

   line_mask_gen #(.N(N)) u_mask (
      .idx  (idx),
      .mask (mask)
   );

   assign hit_a = (a_q & mask) == mask;
   assign hit_b = (b_q & mask) == mask;
   assign clash = |(ain & bin);

   // NOTE: a_q/b_q are data-only and deliberately left out of reset; they are
   // always rewritten on an accepted start before anything reads them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         win_line <= '0;
         winner_a <= 1'b0;
         winner_b <= 1'b0;
         draw     <= 1'b0;
         invalid  <= 1'b0;
      end else begin
         // NOTE: done defaults low every cycle so it can only ever be a pulse.
         done <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_q      <= ain;
                  b_q      <= bin;
                  idx      <= '0;
                  win_line <= '0;
                  winner_a <= 1'b0;
                  winner_b <= 1'b0;
                  draw     <= 1'b0;
                  invalid  <= clash;
                  busy     <= ~clash;
                  state    <= clash ? DONE : SCAN;
               end else if (state == DONE && !done) begin
                  done <= 1'b1;  // invalid board: pulse lands one edge after acceptance
               end else begin
                  state <= IDLE;
               end
            end
            SCAN: begin
               if (hit_a || hit_b) begin
                  win_line <= ONE << idx;
                  winner_a <= hit_a;
                  winner_b <= hit_b;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if (idx == LAST) begin
                  draw  <= &(a_q | b_q);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_win_detector.sv
// Self-checking bench for seq_win_detector: N=3 and N=4 instances, directed
// scenarios plus random boards against a line-by-line reference model.
module tb_seq_win_detector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start3, start4;
   logic [8:0]  ain3, bin3;
   logic [15:0] ain4, bin4;
   logic        busy3, done3, wa3, wb3, dr3, inv3;
   logic        busy4, done4, wa4, wb4, dr4, inv4;
   logic [7:0]  wl3;
   logic [9:0]  wl4;

   int checks = 0;
   int errors = 0;

   bit          big;
   logic [17:0] obs_wl;
   logic        obs_busy, obs_done, obs_wa, obs_wb, obs_dr, obs_inv;

   int          exp_lat;
   logic [17:0] exp_wl;
   logic        exp_wa, exp_wb, exp_dr, exp_inv;

   always #5 clk = ~clk;

   seq_win_detector #(.N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .ain(ain3), .bin(bin3),
      .busy(busy3), .done(done3), .win_line(wl3), .winner_a(wa3),
      .winner_b(wb3), .draw(dr3), .invalid(inv3)
   );

   seq_win_detector #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .ain(ain4), .bin(bin4),
      .busy(busy4), .done(done4), .win_line(wl4), .winner_a(wa4),
      .winner_b(wb4), .draw(dr4), .invalid(inv4)
   );

   always_comb begin
      obs_wl   = big ? 18'(wl4) : 18'(wl3);
      obs_busy = big ? busy4 : busy3;
      obs_done = big ? done4 : done3;
      obs_wa   = big ? wa4   : wa3;
      obs_wb   = big ? wb4   : wb3;
      obs_dr   = big ? dr4   : dr3;
      obs_inv  = big ? inv4  : inv3;
   end

   // Reference: walk the candidate lines in order over the 2-D board; the
   // returned latency is the number of edges after acceptance until done.
   function automatic void ref_model(input int n, input logic [63:0] a, input logic [63:0] b,
                                     output int lat, output logic [17:0] wl,
                                     output logic wa, output logic wb,
                                     output logic dr, output logic inv);
      logic fa, fb;
      int   r, c;
      wl = '0; wa = 1'b0; wb = 1'b0; dr = 1'b0; inv = 1'b0;
      if ((a & b) != 64'd0) begin
         inv = 1'b1;
         lat = 1;
         return;
      end
      for (int k = 0; k < 2 * n + 2; k++) begin
         fa = 1'b1;
         fb = 1'b1;
         for (int i = 0; i < n; i++) begin
            if (k < n)           begin r = k;         c = i;     end
            else if (k < 2 * n)  begin r = i;         c = k - n; end
            else if (k == 2 * n) begin r = i;         c = i;     end
            else                 begin r = n - 1 - i; c = i;     end
            fa = fa & a[n * n - 1 - (r * n + c)];
            fb = fb & b[n * n - 1 - (r * n + c)];
         end
         if (fa || fb) begin
            wl  = 18'd1 << k;
            wa  = fa;
            wb  = fb;
            lat = k + 1;
            return;
         end
      end
      dr = 1'b1;
      for (int i = 0; i < n * n; i++) dr = dr & (a[i] | b[i]);
      lat = 2 * n + 2;
   endfunction

   // Starts a scan from a low clock phase; returns at the low phase of the done cycle.
   task automatic run_scan(input string name, input bit use4, input logic [63:0] a,
                           input logic [63:0] b, input bit noise);
      logic [21:0] got, want;
      big = use4;
      ref_model(use4 ? 4 : 3, a, b, exp_lat, exp_wl, exp_wa, exp_wb, exp_dr, exp_inv);
      if (use4) begin
         ain4 = a[15:0]; bin4 = b[15:0]; start4 = 1'b1;
      end else begin
         ain3 = a[8:0];  bin3 = b[8:0];  start3 = 1'b1;
      end
      @(posedge clk);
      for (int j = 0; j <= exp_lat; j++) begin
         @(negedge clk);
         checks++;
         if (obs_busy !== (!exp_inv && j < exp_lat) || obs_done !== (j == exp_lat)) begin
            errors++;
            $display("FAIL %s handshake cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                     name, j, obs_busy, obs_done, (!exp_inv && j < exp_lat), (j == exp_lat));
         end
         if (j == 0 || j == exp_lat) begin
            got  = {obs_wl, obs_wa, obs_wb, obs_dr, obs_inv};
            want = (j == exp_lat) ? {exp_wl, exp_wa, exp_wb, exp_dr, exp_inv}
                                  : {18'd0, 3'b000, exp_inv};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL %s results cycle %0d: {wl,a,b,draw,inv}=%h, required %h",
                        name, j, got, want);
            end
         end
         if (j < exp_lat) begin
            start3 = (noise && !exp_inv && !use4) ? 1'($urandom_range(0, 1)) : 1'b0;
            start4 = (noise && !exp_inv &&  use4) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise && !exp_inv) begin
               if (use4) begin ain4 = 16'($urandom); bin4 = 16'($urandom); end
               else      begin ain3 = 9'($urandom);  bin3 = 9'($urandom);  end
            end
            @(posedge clk);
         end
      end
      start3 = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic test_hold(input string name);
      logic [23:0] got, want;
      @(posedge clk);
      @(negedge clk);
      got  = {obs_done, obs_busy, obs_wl, obs_wa, obs_wb, obs_dr, obs_inv};
      want = {2'b00, exp_wl, exp_wa, exp_wb, exp_dr, exp_inv};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s hold: {done,busy,wl,a,b,draw,inv}=%h, required %h", name, got, want);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start3 = 1'b1; ain3 = 9'h1C0; bin3 = 9'h000;
      start4 = 1'b1; ain4 = 16'hF000; bin4 = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy3, done3, wl3, wa3, wb3, dr3, inv3} !== 14'd0) begin
         errors++;
         $display("FAIL reset_n3: outputs=%h, required 0", {busy3, done3, wl3, wa3, wb3, dr3, inv3});
      end
      checks++;
      if ({busy4, done4, wl4, wa4, wb4, dr4, inv4} !== 16'd0) begin
         errors++;
         $display("FAIL reset_n4: outputs=%h, required 0", {busy4, done4, wl4, wa4, wb4, dr4, inv4});
      end
      rst_n = 1'b1;
      start3 = 1'b0;
      start4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_row_win;
      run_scan("row0", 1'b0, 64'h1C0, 64'h000, 1'b0);
      checks++;
      if (obs_wl !== 18'h01 || obs_wa !== 1'b1 || obs_dr !== 1'b0) begin
         errors++;
         $display("FAIL row0_literal: wl=%h a=%b draw=%b, required wl=01 a=1 draw=0", obs_wl, obs_wa, obs_dr);
      end
      test_hold("row0");
   endtask

   task automatic test_diagonals;
      run_scan("diag_dn_a", 1'b0, 64'h111, 64'h000, 1'b1);
      checks++;
      if (obs_wl !== 18'h40 || obs_wa !== 1'b1) begin
         errors++;
         $display("FAIL diag_dn_literal: wl=%h a=%b, required wl=40 a=1", obs_wl, obs_wa);
      end
      test_hold("diag_dn_a");
      run_scan("diag_up_b", 1'b0, 64'h000, 64'h054, 1'b1);
      checks++;
      if (obs_wl !== 18'h80 || obs_wb !== 1'b1 || obs_wa !== 1'b0) begin
         errors++;
         $display("FAIL diag_up_literal: wl=%h a=%b b=%b, required wl=80 a=0 b=1", obs_wl, obs_wa, obs_wb);
      end
      test_hold("diag_up_b");
   endtask

   task automatic test_back_to_back;
      run_scan("draw", 1'b0, 64'h18D, 64'h072, 1'b1);
      checks++;
      if (obs_dr !== 1'b1 || obs_wl !== 18'h0) begin
         errors++;
         $display("FAIL draw_literal: draw=%b wl=%h, required draw=1 wl=0", obs_dr, obs_wl);
      end
      run_scan("b2b_row1", 1'b0, 64'h038, 64'h000, 1'b0);
      test_hold("b2b_row1");
   endtask

   task automatic test_invalid;
      run_scan("invalid", 1'b0, 64'h001, 64'h001, 1'b0);
      checks++;
      if (obs_inv !== 1'b1 || obs_wl !== 18'h0) begin
         errors++;
         $display("FAIL invalid_literal: invalid=%b wl=%h, required invalid=1 wl=0", obs_inv, obs_wl);
      end
      test_hold("invalid");
   endtask

   task automatic test_reset_mid_scan;
      big = 1'b0;
      ain3 = 9'h111; bin3 = 9'h000; start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy3, done3, wl3, wa3, wb3, dr3, inv3} !== 14'd0) begin
         errors++;
         $display("FAIL reset_mid_scan: outputs=%h, required 0", {busy3, done3, wl3, wa3, wb3, dr3, inv3});
      end
      rst_n = 1'b1;
      start3 = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         checks++;
         if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan_quiet cycle %0d: done=%b busy=%b, required 0 0", j, done3, busy3);
         end
      end
   endtask

   task automatic test_n4_col;
      run_scan("n4_col1", 1'b1, 64'h4444, 64'h0000, 1'b1);
      checks++;
      if (obs_wl !== 18'h020 || obs_wa !== 1'b1) begin
         errors++;
         $display("FAIL n4_col1_literal: wl=%h a=%b, required wl=020 a=1", obs_wl, obs_wa);
      end
      test_hold("n4_col1");
   endtask

   task automatic test_random;
      logic [63:0] a, b, msk;
      bit          use4;
      for (int it = 0; it < 3000; it++) begin
         use4 = 1'($urandom_range(0, 1));
         msk  = use4 ? 64'hFFFF : 64'h1FF;
         a    = {$urandom, $urandom} & msk;
         case ($urandom_range(0, 7))
            0:       b = {$urandom, $urandom} & msk;
            1:       b = ~a & msk;
            default: b = {$urandom, $urandom} & msk & ~a;
         endcase
         run_scan(use4 ? "rand_n4" : "rand_n3", use4, a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) test_hold("rand");
      end
   endtask

   initial begin
      big = 1'b0;
      test_reset;
      test_row_win;
      test_diagonals;
      test_back_to_back;
      test_invalid;
      test_reset_mid_scan;
      test_n4_col;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule
